// File: rtl/rx_frame_ctrl.sv
// Receive frame controller: drains the RxCore byte FIFO to a valid/ready host port and closes
// frames after an idle gap of acquisition ticks. Define RX_ERROR_COUNT_EN to build ErrorCount_o.
module rx_frame_ctrl #(
    parameter int unsigned FRAME_TIMEOUT = 16,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       Data_i,
    output logic             n_Rd_o,
    input  logic             p_Empty_i,
    input  logic             AcqSig_i,
    input  logic             p_BaudrateError_i,
    input  logic             p_ParityError_i,
    output logic [7:0]       Data_o,
    output logic             p_Valid_o,
    input  logic             p_Ready_i,
    output logic             p_FrameEnd_o,
    output logic [CNT_W-1:0] ByteCount_o,
    output logic             p_FrameError_o,
    output logic [7:0]       ErrorCount_o
);
    localparam int unsigned       IDLE_W      = 8;
    localparam logic [IDLE_W-1:0] TIMEOUT_VAL = IDLE_W'(FRAME_TIMEOUT);
    localparam logic [CNT_W-1:0]  BYTE_MAX    = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_HOLD,
        S_FEND
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [IDLE_W-1:0] idle_cnt_nxt;
    logic              n_rd_nxt;
    logic              valid_nxt;
    logic              fend_nxt;
    logic              ferr_nxt;
    logic [7:0]        data_nxt;
    logic [CNT_W-1:0]  bcnt_nxt;
    logic              err_any;
    logic              accept;
    logic              tick;
    logic              timeout_hit;

    // An idle tick only counts with an open frame, nothing held and nothing waiting in the FIFO.
    assign err_any     = p_BaudrateError_i | p_ParityError_i;
    assign accept      = (state == S_HOLD) && p_Ready_i;
    assign tick        = (state == S_IDLE) && p_Empty_i && (ByteCount_o != '0) && AcqSig_i;
    assign timeout_hit = tick && ((idle_cnt + IDLE_W'(1)) == TIMEOUT_VAL);

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            idle_cnt       <= '0;
            n_Rd_o         <= 1'b1;
            Data_o         <= '0;
            p_Valid_o      <= 1'b0;
            p_FrameEnd_o   <= 1'b0;
            ByteCount_o    <= '0;
            p_FrameError_o <= 1'b0;
        end else begin
            state          <= state_nxt;
            idle_cnt       <= idle_cnt_nxt;
            n_Rd_o         <= n_rd_nxt;
            Data_o         <= data_nxt;
            p_Valid_o      <= valid_nxt;
            p_FrameEnd_o   <= fend_nxt;
            ByteCount_o    <= bcnt_nxt;
            p_FrameError_o <= ferr_nxt;
        end
    end

    // Next-state logic; a pending FIFO byte beats the terminal idle tick
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!p_Empty_i) begin
                    state_nxt = S_READ;
                end else if (timeout_hit) begin
                    state_nxt = S_FEND;
                end
            end
            S_READ:    state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_HOLD;
            S_HOLD:    if (p_Ready_i) state_nxt = S_IDLE;
            S_FEND:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and the idle timer
    always_comb begin
        n_rd_nxt     = (state_nxt != S_READ);
        valid_nxt    = (state_nxt == S_HOLD);
        fend_nxt     = (state_nxt == S_FEND);
        data_nxt     = (state == S_CAPTURE) ? Data_i : Data_o;
        bcnt_nxt     = ByteCount_o;
        idle_cnt_nxt = idle_cnt;
        ferr_nxt     = p_FrameError_o | err_any;
        if (state == S_FEND) begin
            bcnt_nxt = '0;
            ferr_nxt = err_any;
        end
        if (accept) begin
            idle_cnt_nxt = '0;
            if (ByteCount_o != BYTE_MAX) begin
                bcnt_nxt = ByteCount_o + CNT_W'(1);
            end
        end else if (timeout_hit) begin
            idle_cnt_nxt = '0;
        end else if (tick) begin
            idle_cnt_nxt = idle_cnt + IDLE_W'(1);
        end
    end

`ifdef RX_ERROR_COUNT_EN
    logic err_q;

    // Saturating count of rising edges of the combined error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q        <= 1'b0;
            ErrorCount_o <= '0;
        end else begin
            err_q <= err_any;
            if (err_any && !err_q && (ErrorCount_o != 8'hFF)) begin
                ErrorCount_o <= ErrorCount_o + 8'd1;
            end
        end
    end
`else
    assign ErrorCount_o = '0;
`endif

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: FIFO/host environment, transaction-level expectation model,
// directed scenarios and a randomized soak. Follows RX_ERROR_COUNT_EN like the design.
module tb_rx_frame_ctrl;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CNT_W   = 8;
    localparam int          BC_MAX  = (1 << CNT_W) - 1;
`ifdef RX_ERROR_COUNT_EN
    localparam int          EXP_EC  = 1;
`else
    localparam int          EXP_EC  = 0;
`endif

    logic             clk;
    logic             rst;
    logic [7:0]       data_in;
    logic             n_rd;
    logic             empty;
    logic             acq;
    logic             baud_err;
    logic             par_err;
    logic [7:0]       data_out;
    logic             valid;
    logic             ready;
    logic             fend;
    logic [CNT_W-1:0] bcnt;
    logic             ferr;
    logic [7:0]       ecnt;

    rx_frame_ctrl #(.FRAME_TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .Data_i           (data_in),
        .n_Rd_o           (n_rd),
        .p_Empty_i        (empty),
        .AcqSig_i         (acq),
        .p_BaudrateError_i(baud_err),
        .p_ParityError_i  (par_err),
        .Data_o           (data_out),
        .p_Valid_o        (valid),
        .p_Ready_i        (ready),
        .p_FrameEnd_o     (fend),
        .ByteCount_o      (bcnt),
        .p_FrameError_o   (ferr),
        .ErrorCount_o     (ecnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stimulus knobs: mode 0 = low/always-ready, 1 = high/never-ready, 2 = random
    int ready_mode = 0;
    int acq_mode   = 0;
    int err_mode   = 0;
    bit par_pulse  = 1'b0;
    bit release_rst = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Observed events, used by the directed literal checks
    int         rd_cnt = 0, last_rd_cyc = 0, last_vrise_cyc = 0;
    int         fend_cnt = 0, last_fend_cyc = 0, last_fend_bc = 0;
    bit         last_fend_ferr = 1'b0, prev_valid = 1'b0;
    int         last_acc_cyc = 0;
    logic [7:0] last_acc_data = 8'h00;
    int         acc_cyc_q[$];
    logic [7:0] acc_dat_q[$];

    logic [7:0] fifo[$];

    // Expectation model: what each output must show in the coming cycle
    bit         m_nrd, m_valid, m_fend, m_ferr;
    logic [7:0] m_data;
    int         m_bc, m_ec, idle_ticks;
    bit         in_flight, m_cap, err_prev;

    task automatic model_reset();
        m_nrd = 1'b1; m_valid = 1'b0; m_fend = 1'b0; m_ferr = 1'b0;
        m_data = 8'h00; m_bc = 0; m_ec = 0; idle_ticks = 0;
        in_flight = 1'b0; m_cap = 1'b0; err_prev = 1'b0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock: compare, serve the FIFO, drive inputs, advance the model
    task automatic step();
        bit acc, tk, cap_now, old_fend, ev, nf;
        @(negedge clk);
        cyc++;
        chk("n_Rd_o",         int'(n_rd),     int'(m_nrd));
        chk("Data_o",         int'(data_out), int'(m_data));
        chk("p_Valid_o",      int'(valid),    int'(m_valid));
        chk("p_FrameEnd_o",   int'(fend),     int'(m_fend));
        chk("ByteCount_o",    int'(bcnt),     m_bc);
        chk("p_FrameError_o", int'(ferr),     int'(m_ferr));
        chk("ErrorCount_o",   int'(ecnt),     m_ec);
        if (!n_rd) begin rd_cnt++; last_rd_cyc = cyc; end
        if (valid && !prev_valid) last_vrise_cyc = cyc;
        prev_valid = valid;
        if (fend) begin
            fend_cnt++; last_fend_cyc = cyc; last_fend_bc = int'(bcnt); last_fend_ferr = ferr;
        end

        if (rst && !n_rd) begin
            if (fifo.size() != 0) data_in = fifo.pop_front();
            else data_in = 8'h00;
        end else if (!in_flight) begin
            data_in = 8'($urandom);
        end
        if (rst && !m_nrd) in_flight = 1'b1;

        if (release_rst) begin rst = 1'b1; release_rst = 1'b0; end
        empty = (fifo.size() == 0);
        case (ready_mode)
            0:       ready = 1'b1;
            1:       ready = 1'b0;
            default: ready = ($urandom_range(3) != 0);
        endcase
        case (acq_mode)
            0:       acq = 1'b0;
            1:       acq = 1'b1;
            default: acq = ($urandom_range(2) == 0);
        endcase
        par_err  = rst && (par_pulse || (err_mode != 0 && $urandom_range(49) == 0));
        baud_err = rst && (err_mode != 0 && $urandom_range(49) == 0);
        par_pulse = 1'b0;

        if (rst) begin
            if (valid && ready) begin
                last_acc_cyc = cyc; last_acc_data = data_out;
                acc_cyc_q.push_back(cyc); acc_dat_q.push_back(data_out);
            end
            ev       = baud_err | par_err;
            acc      = m_valid && ready;
            cap_now  = m_cap;
            old_fend = m_fend;
            tk       = acq && empty && !in_flight && (m_bc != 0) && !m_fend;
            nf       = 1'b0;
            m_cap    = !m_nrd;
            m_nrd    = !(!empty && !in_flight && !m_fend);
            if (cap_now) m_data = data_in;
            if (acc) m_valid = 1'b0;
            else if (cap_now) m_valid = 1'b1;
            if (acc) begin
                idle_ticks = 0;
                in_flight  = 1'b0;
                if (m_bc < BC_MAX) m_bc++;
            end else if (tk) begin
                idle_ticks++;
                if (idle_ticks == int'(TIMEOUT)) begin nf = 1'b1; idle_ticks = 0; end
            end
            if (old_fend) m_bc = 0;
            m_fend = nf;
            m_ferr = old_fend ? ev : (m_ferr | ev);
`ifdef RX_ERROR_COUNT_EN
            if (ev && !err_prev && m_ec < 255) m_ec++;
`endif
            err_prev = ev;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int b, a, f0, rd0;

    initial begin
        rst = 1'b1; data_in = 8'h00; empty = 1'b1; acq = 1'b0;
        baud_err = 1'b0; par_err = 1'b0; ready = 1'b0;
        model_reset();
        #2 rst = 1'b0;
        #1;
        chk("reset n_Rd_o", int'(n_rd), 1);
        chk("reset Data_o", int'(data_out), 0);
        chk("reset p_Valid_o", int'(valid), 0);
        chk("reset p_FrameEnd_o", int'(fend), 0);
        chk("reset ByteCount_o", int'(bcnt), 0);
        chk("reset p_FrameError_o", int'(ferr), 0);
        chk("reset ErrorCount_o", int'(ecnt), 0);
        run(2);
        release_rst = 1'b1;
        run(3);

        // Single byte, then a frame closed by 16 idle ticks
        ready_mode = 0; acq_mode = 1;
        run(4);
        f0 = fend_cnt; rd0 = rd_cnt;
        fifo.push_back(8'hA5);
        step(); b = cyc;
        run(21);
        chk("t1 reads", rd_cnt - rd0, 1);
        chk("t1 read cycle", last_rd_cyc, b + 1);
        chk("t1 valid rise", last_vrise_cyc, b + 3);
        chk("t1 accept cycle", last_acc_cyc, b + 3);
        chk("t1 accept data", int'(last_acc_data), 8'hA5);
        chk("t1 frame ends", fend_cnt - f0, 1);
        chk("t1 frame end cycle", last_fend_cyc, b + 20);
        chk("t1 frame length", last_fend_bc, 1);
        chk("t1 count cleared", int'(bcnt), 0);

        // Three back-to-back bytes
        acc_cyc_q.delete(); acc_dat_q.delete();
        f0 = fend_cnt;
        fifo.push_back(8'h01); fifo.push_back(8'h02); fifo.push_back(8'h03);
        run(40);
        chk("t2 transfers", acc_cyc_q.size(), 3);
        chk("t2 byte0", int'(acc_dat_q[0]), 8'h01);
        chk("t2 byte1", int'(acc_dat_q[1]), 8'h02);
        chk("t2 byte2", int'(acc_dat_q[2]), 8'h03);
        chk("t2 spacing01", acc_cyc_q[1] - acc_cyc_q[0], 4);
        chk("t2 spacing12", acc_cyc_q[2] - acc_cyc_q[1], 4);
        chk("t2 frame ends", fend_cnt - f0, 1);
        chk("t2 frame length", last_fend_bc, 3);

        // Host stall with a second byte waiting
        ready_mode = 1;
        fifo.push_back(8'h11); fifo.push_back(8'h22);
        run(4);
        rd0 = rd_cnt; f0 = fend_cnt;
        run(50);
        chk("t3 valid held", int'(valid), 1);
        chk("t3 data held", int'(data_out), 8'h11);
        chk("t3 no reads", rd_cnt - rd0, 0);
        chk("t3 no frame end", fend_cnt - f0, 0);
        ready_mode = 0;
        run(60);
        chk("t3 frame ends", fend_cnt - f0, 1);
        chk("t3 frame length", last_fend_bc, 2);

        // Byte arrives on the terminal idle tick
        fifo.push_back(8'h44);
        run(4); a = cyc;
        chk("t4 accept cycle", last_acc_cyc, a);
        run(15);
        fifo.push_back(8'h55);
        step();
        f0 = fend_cnt;
        run(5);
        chk("t4 no frame end", fend_cnt - f0, 0);
        run(25);
        chk("t4 frame ends", fend_cnt - f0, 1);
        chk("t4 frame end cycle", last_fend_cyc, a + 36);
        chk("t4 frame length", last_fend_bc, 2);

        // Parity error pulse mid-frame
        fifo.push_back(8'h66); fifo.push_back(8'h77);
        run(3);
        par_pulse = 1'b1;
        step();
        step();
        chk("t5 error flag set", int'(ferr), 1);
        run(40);
        chk("t5 flag at frame end", int'(last_fend_ferr), 1);
        chk("t5 flag cleared", int'(ferr), 0);
        chk("t5 frame length", last_fend_bc, 2);
        chk("t5 error count", int'(ecnt), EXP_EC);

        // Reset while holding 0x5A; the FIFO keeps 0x3C
        acq_mode = 0;
        fifo.push_back(8'h33); fifo.push_back(8'h5A); fifo.push_back(8'h3C);
        run(4);
        ready_mode = 1;
        run(4);
        chk("t6 holding data", int'(data_out), 8'h5A);
        chk("t6 holding valid", int'(valid), 1);
        chk("t6 count before reset", int'(bcnt), 1);
        rst = 1'b0;
        #1;
        chk("t6 valid after reset", int'(valid), 0);
        chk("t6 count after reset", int'(bcnt), 0);
        chk("t6 data after reset", int'(data_out), 0);
        chk("t6 strobe after reset", int'(n_rd), 1);
        model_reset();
        run(2);
        release_rst = 1'b1; ready_mode = 0; acq_mode = 1;
        run(6);
        chk("t6 byte after reset", int'(last_acc_data), 8'h3C);
        run(25);
        chk("t6 frame length", last_fend_bc, 1);

        // Byte counter saturation
        acq_mode = 0;
        for (int i = 0; i < 260; i++) fifo.push_back(8'(i));
        run(260 * 4 + 10);
        chk("t7 saturated count", int'(bcnt), BC_MAX);
        acq_mode = 1;
        run(25);
        chk("t7 frame length", last_fend_bc, BC_MAX);

        // Randomized soak
        ready_mode = 2; acq_mode = 2; err_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) fifo.push_back(8'($urandom));
            step();
        end
        err_mode = 0; ready_mode = 0; acq_mode = 1;
        run(300);
        chk("soak fifo drained", fifo.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rx_frame_ctrl.md
# rx_frame_ctrl

Receive-side controller that drains the RxCore byte FIFO and hands each byte to the host over a valid/ready handshake. It sequences the FIFO's active-low read strobe and delimits frames by detecting an idle gap measured in acquisition ticks. It latches the RxCore baudrate and parity error flags per frame. It sits between RxCore and the UartCore register/host interface.

## Interface
Parameters:
- FRAME_TIMEOUT, 16: number of AcqSig_i ticks of idle (FIFO empty, no byte held) that closes a frame; legal range 1..255.
- CNT_W, 8: width of the frame byte counter.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  reset, asynchronous, active-low.
- Data_i  in  8  byte from RxCore FIFO; valid the cycle after n_Rd_o is low.
- n_Rd_o  out  1  FIFO read strobe, active-low, exactly one cycle per byte.
- p_Empty_i  in  1  FIFO empty, active-high.
- AcqSig_i  in  1  acquisition tick, one-cycle pulse.
- p_BaudrateError_i  in  1  RxCore baudrate error flag.
- p_ParityError_i  in  1  RxCore parity error flag.
- Data_o  out  8  byte to host.
- p_Valid_o  out  1  Data_o valid.
- p_Ready_i  in  1  host accepts byte.
- p_FrameEnd_o  out  1  one-cycle pulse when a frame closes.
- ByteCount_o  out  CNT_W  bytes transferred in the current frame; holds the final length during the p_FrameEnd_o cycle.
- p_FrameError_o  out  1  sticky: an error flag was seen during the current frame.
- ErrorCount_o  out  8  error event counter (see Configuration).

## Operation
- Reset values: n_Rd_o=1, Data_o=0, p_Valid_o=0, p_FrameEnd_o=0, ByteCount_o=0, p_FrameError_o=0, ErrorCount_o=0, idle counter=0, state IDLE.
- FSM states:
  - IDLE: if p_Empty_i=0 -> READ; else run the idle timer.
  - READ: n_Rd_o=0 for this cycle only -> CAPTURE.
  - CAPTURE: register Data_i into Data_o -> HOLD.
  - HOLD: p_Valid_o=1; Data_o is stable. When p_Valid_o & p_Ready_i at a clock edge: ByteCount_o+1 (saturates at 2^CNT_W-1), idle counter cleared -> IDLE.
  - FEND: p_FrameEnd_o=1 for one cycle -> IDLE. ByteCount_o and p_FrameError_o clear on leaving FEND.
- Idle timer:
  - In IDLE with p_Empty_i=1 and ByteCount_o≠0, each AcqSig_i pulse increments the idle counter.
  - When the counter reaches FRAME_TIMEOUT -> FEND, and the counter clears.
  - When ByteCount_o=0 the timer does not run, so no empty frames are produced.
- Priority: if p_Empty_i=0 in the same cycle as the terminal tick, the read wins (-> READ); the counter keeps its value and clears on the next transfer.
- Errors: p_FrameError_o is set in any cycle where either error input is high, in any state.
  - If an error input is high in the FEND cycle, the flag is set again on the next cycle, so it carries into the following frame.
- The host holding p_Ready_i=0 stalls in HOLD indefinitely. No further FIFO reads occur, and the idle timer is frozen.

## Timing
- p_Empty_i sampled low at edge N: n_Rd_o low in cycle N+1, Data_o updated at edge N+2, p_Valid_o high from cycle N+3.
- Minimum byte period is 4 cycles with p_Ready_i held high: READ, CAPTURE, HOLD, IDLE.
- p_Valid_o drops in the cycle after the accepting edge.
- p_FrameEnd_o asserts in the cycle after the edge at which the terminal AcqSig_i tick is counted.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). A byte held in HOLD is discarded. Bytes still in the FIFO are preserved and read after reset release.
- All outputs are registered.

## Configuration
- RX_ERROR_COUNT_EN defined: ErrorCount_o counts rising edges of (p_BaudrateError_i | p_ParityError_i), saturates at 255, and is cleared only by rst.
- RX_ERROR_COUNT_EN undefined: the counter logic is removed and ErrorCount_o is tied to 0. The port is always present.

## Test plan
- Single byte 0xA5, p_Ready_i=1: n_Rd_o low exactly 1 cycle, p_Valid_o with Data_o=0xA5 three cycles after empty drops. After 16 AcqSig_i ticks: p_FrameEnd_o pulse with ByteCount_o=1, then ByteCount_o=0.
- Three back-to-back bytes 0x01,0x02,0x03 with p_Ready_i=1: transfers spaced 4 cycles apart, in order. Single p_FrameEnd_o with ByteCount_o=3.
- p_Ready_i held 0 for 50 cycles with a second byte waiting: Data_o stable and p_Valid_o=1 throughout, n_Rd_o stays 1, and no p_FrameEnd_o pulse even if AcqSig_i keeps ticking.
- New byte arrives (p_Empty_i=0) on the 16th idle tick: no p_FrameEnd_o. The frame continues and the final ByteCount_o=2.
- p_ParityError_i pulsed for 1 cycle mid-frame: p_FrameError_o=1 until the FEND cycle, then 0. With RX_ERROR_COUNT_EN, ErrorCount_o=1.
- rst asserted while in HOLD with 0x5A: p_Valid_o=0 and ByteCount_o=0 immediately. After release the next FIFO byte is read normally.
